// File: rtl/block_header_assembler.sv
// block_header_assembler
//
// Collects a framed byte stream into a block header for the downstream miner.
// A frame is one sync byte, HEADER_BYTES payload bytes and one checksum byte
// (the XOR of the payload bytes). A frame with a good checksum updates
// Block_Header and pulses Block_Header_Valid for one cycle. A frame with a bad
// checksum, or one that stalls for TIMEOUT_CYCLES idle cycles, is dropped and
// frame_error pulses for one cycle. Block_Header is left untouched in that case.
//
// Ports:
//   clk                 system clock, rising edge
//   rst_n               asynchronous active-low reset
//   rx_data[7:0]        received byte
//   rx_valid            rx_data is valid this cycle (one byte per strobe)
//   Block_Header[639:0] last accepted header; first payload byte in the top byte
//   Block_Header_Valid  one-cycle pulse: Block_Header was just updated
//   frame_error         one-cycle pulse: a frame was discarded
//   busy                a frame is in progress
module block_header_assembler #(
  parameter int unsigned HEADER_BYTES   = 80,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic [8*HEADER_BYTES-1:0] Block_Header,
  output logic                      Block_Header_Valid,
  output logic                      frame_error,
  output logic                      busy
);

  localparam int unsigned HdrW = 8 * HEADER_BYTES;
  localparam int unsigned ToW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [6:0]     LastIdx = 7'(HEADER_BYTES - 1);
  localparam logic [ToW-1:0] ToMax   = ToW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StPayload  = 2'd1;
  localparam logic [1:0] StChecksum = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [7:0]      csum_q, csum_d;
  logic [ToW-1:0]  to_q, to_d;
  logic [HdrW-1:0] shadow_q, shadow_d;
  logic [HdrW-1:0] hdr_q, hdr_d;
  logic            hv_q, hv_d;
  logic            fe_q, fe_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    to_d     = to_q;
    shadow_d = shadow_q;
    hdr_d    = hdr_q;
    hv_d     = 1'b0;
    fe_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = StPayload;
          cnt_d   = '0;
          csum_d  = '0;
          to_d    = '0;
        end
      end

      StPayload: begin
        if (rx_valid) begin
          // Shifting in from the bottom leaves byte k at [HdrW-1-8k -: 8] once
          // all HEADER_BYTES bytes have arrived.
          shadow_d = {shadow_q[HdrW-9:0], rx_data};
          csum_d   = csum_q ^ rx_data;
          cnt_d    = cnt_q + 7'd1;
          to_d     = '0;
          if (cnt_q == LastIdx) begin
            state_d = StChecksum;
          end
        end
      end

      StChecksum: begin
        if (rx_valid) begin
          to_d    = '0;
          state_d = StIdle;
          if (rx_data == csum_q) begin
            hdr_d = shadow_q;
            hv_d  = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Idle-gap watchdog inside a frame; a byte in the same cycle always wins.
    // The counter never passes ToMax because reaching it ends the frame.
    if ((state_q != StIdle) && !rx_valid) begin
      if (to_q == ToMax) begin
        state_d = StIdle;
        fe_d    = 1'b1;
        to_d    = '0;
      end else begin
        to_d = to_q + ToW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      csum_q   <= '0;
      to_q     <= '0;
      shadow_q <= '0;
      hdr_q    <= '0;
      hv_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      csum_q   <= csum_d;
      to_q     <= to_d;
      shadow_q <= shadow_d;
      hdr_q    <= hdr_d;
      hv_q     <= hv_d;
      fe_q     <= fe_d;
    end
  end

  assign Block_Header       = hdr_q;
  assign Block_Header_Valid = hv_q;
  assign frame_error        = fe_q;
  assign busy               = (state_q != StIdle);

endmodule

// File: tb/tb_block_header_assembler.sv
module tb_block_header_assembler;

  localparam int unsigned To = 16;
  localparam logic [639:0] SeqHdr =
    640'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F202122232425262728292A2B2C2D2E2F303132333435363738393A3B3C3D3E3F404142434445464748494A4B4C4D4E4F;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic [639:0] hdr;
  logic         hv;
  logic         fe;
  logic         busy;

  block_header_assembler #(
    .HEADER_BYTES  (80),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(To)
  ) u_dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .Block_Header      (hdr),
    .Block_Header_Valid(hv),
    .frame_error       (fe),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: frame parser over a byte queue ----------------
  bit           m_in = 1'b0;
  logic [7:0]   m_q[$];
  int           m_idle = 0;
  logic [639:0] e_hdr = '0;
  bit           e_v = 1'b0;
  bit           e_err = 1'b0;
  bit           e_busy = 1'b0;

  function automatic logic [7:0] q_xor();
    logic [7:0] x = 8'h00;
    foreach (m_q[i]) x ^= m_q[i];
    return x;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_in = 1'b0;
      m_q.delete();
      m_idle = 0;
      e_hdr = '0;
      e_v = 1'b0;
      e_err = 1'b0;
      e_busy = 1'b0;
    end else begin
      e_v = 1'b0;
      e_err = 1'b0;
      if (!m_in) begin
        if (rx_valid && rx_data == 8'hA5) begin
          m_in = 1'b1;
          m_q.delete();
          m_idle = 0;
        end
      end else if (rx_valid) begin
        m_idle = 0;
        if (m_q.size() < 80) begin
          m_q.push_back(rx_data);
        end else begin
          if (q_xor() == rx_data) begin
            for (int i = 0; i < 80; i++) e_hdr[639-8*i -: 8] = m_q[i];
            e_v = 1'b1;
          end else begin
            e_err = 1'b1;
          end
          m_in = 1'b0;
        end
      end else begin
        m_idle++;
        if (m_idle >= To) begin
          e_err = 1'b1;
          m_in = 1'b0;
        end
      end
      e_busy = m_in;
    end
  end

  // Compare every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("hdr", hdr, e_hdr);
      chk("valid", {639'd0, hv}, {639'd0, e_v});
      chk("frame_error", {639'd0, fe}, {639'd0, e_err});
      chk("busy", {639'd0, busy}, {639'd0, e_busy});
    end
  end

  // Pulse bookkeeping for the directed literal checks.
  int cyc = 0;
  int vcnt = 0;
  int ecnt = 0;
  int vcyc[$];
  initial forever begin
    @(negedge clk);
    cyc++;
    if (hv === 1'b1) begin
      vcnt++;
      vcyc.push_back(cyc);
    end
    if (fe === 1'b1) ecnt++;
  end

  // ---------------- stimulus ----------------
  logic [7:0] pl[80];

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #2;
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      rx_valid = 1'b0;
    end
  endtask

  task automatic fill_seq(input logic [7:0] base);
    for (int i = 0; i < 80; i++) pl[i] = 8'(i) + base;
  endtask

  function automatic logic [7:0] pl_xor();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 80; i++) x ^= pl[i];
    return x;
  endfunction

  task automatic send_frame(input logic [7:0] csum_flip);
    send_byte(8'hA5);
    for (int i = 0; i < 80; i++) send_byte(pl[i]);
    send_byte(pl_xor() ^ csum_flip);
  endtask

  int v0, e0;

  initial begin
    #12;
    chk("reset_hdr", hdr, '0);
    chk("reset_valid", {639'd0, hv}, '0);
    chk("reset_err", {639'd0, fe}, '0);
    chk("reset_busy", {639'd0, busy}, '0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // 1: sequential payload, checksum 00
    v0 = vcnt; e0 = ecnt;
    fill_seq(8'h00);
    chk("t1_xor_const", {632'd0, pl_xor()}, {632'd0, 8'h00});
    send_frame(8'h00);
    idle(2);
    chk("t1_hdr", hdr, SeqHdr);
    chk("t1_pulses", 640'(vcnt - v0), 640'd1);
    chk("t1_errs", 640'(ecnt - e0), 640'd0);

    // 2: bad checksum, then an all-FF good frame
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h01);
    idle(2);
    chk("t2_errs", 640'(ecnt - e0), 640'd1);
    chk("t2_pulses", 640'(vcnt - v0), 640'd0);
    chk("t2_hdr_held", hdr, SeqHdr);
    for (int i = 0; i < 80; i++) pl[i] = 8'hFF;
    send_frame(8'h00);
    idle(2);
    chk("t2_ff_hdr", hdr, {640{1'b1}});
    chk("t2_ff_pulses", 640'(vcnt - v0), 640'd1);

    // 3: junk before sync, A5 inside payload
    v0 = vcnt; e0 = ecnt;
    send_byte(8'h11);
    send_byte(8'h22);
    fill_seq(8'h00);
    pl[10] = 8'hA5;
    chk("t3_xor_const", {632'd0, pl_xor()}, {632'd0, 8'hAF});
    send_frame(8'h00);
    idle(2);
    chk("t3_byte10", {632'd0, hdr[559:552]}, {632'd0, 8'hA5});
    chk("t3_byte0", {632'd0, hdr[639:632]}, {632'd0, 8'h00});
    chk("t3_pulses", 640'(vcnt - v0), 640'd1);
    chk("t3_errs", 640'(ecnt - e0), 640'd0);

    // 4: stall after 40 payload bytes
    v0 = vcnt; e0 = ecnt;
    fill_seq(8'h20);
    send_byte(8'hA5);
    for (int i = 0; i < 40; i++) send_byte(pl[i]);
    idle(1);
    chk("t4_busy_mid", {639'd0, busy}, {639'd0, 1'b1});
    idle(To + 2);
    chk("t4_errs", 640'(ecnt - e0), 640'd1);
    chk("t4_busy_after", {639'd0, busy}, '0);
    chk("t4_pulses", 640'(vcnt - v0), 640'd0);
    send_frame(8'h00);
    idle(2);
    chk("t4_recover", 640'(vcnt - v0), 640'd1);

    // 5: two frames back-to-back, rx_valid continuously high
    v0 = vcnt;
    fill_seq(8'h00);
    send_frame(8'h00);
    fill_seq(8'h80);
    send_frame(8'h00);
    idle(2);
    chk("t5_pulses", 640'(vcnt - v0), 640'd2);
    if (vcnt - v0 >= 2)
      chk("t5_gap", 640'(vcyc[vcyc.size()-1] - vcyc[vcyc.size()-2]), 640'd82);
    chk("t5_top", {632'd0, hdr[639:632]}, {632'd0, 8'h80});
    chk("t5_bot", {632'd0, hdr[7:0]}, {632'd0, 8'hCF});

    // 6: asynchronous reset mid-frame
    v0 = vcnt; e0 = ecnt;
    fill_seq(8'h00);
    send_byte(8'hA5);
    for (int i = 0; i < 50; i++) send_byte(pl[i]);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    rx_valid = 1'b0;
    #1;
    chk("t6_hdr_async", hdr, '0);
    chk("t6_busy_async", {639'd0, busy}, '0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 50; i < 80; i++) send_byte(pl[i]);
    send_byte(pl_xor());
    idle(3);
    chk("t6_pulses", 640'(vcnt - v0), 640'd0);
    chk("t6_errs", 640'(ecnt - e0), 640'd0);
    chk("t6_hdr", hdr, '0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
